// File: rtl/hp_mul_prep.sv
// hp_mul_prep
// Prepares IEEE half-precision operand pairs for a Booth-style mantissa
// multiplier. Each pair accepted on the input handshake is classified,
// its mantissas are extended with the hidden bit, and its biased exponent
// sum is formed. The prepared entry is then queued in a 2-entry FIFO that
// feeds the multiplier stage.
//
// Ports
//   clk           single clock, rising-edge
//   rst_n         synchronous active-low reset
//   in_valid      upstream operand pair valid
//   in_ready      registered; high when the FIFO has room
//   hp_inA/hp_inB half-precision operands {sign, exp[4:0], man[9:0]}
//   out_valid     head entry valid (FIFO not empty)
//   out_ready     multiplier stage consumes the head entry
//   booth_manA    {3'b001, man_A} for normal pairs, else 0
//   booth_manB    {2'b01, man_B, 1'b0} for normal pairs, else 0
//   exp_sum       signed 7-bit exp_A + exp_B - 15 for normal pairs, else 0
//   sign_product  sign_A ^ sign_B, for every class
//   op_class      00 normal, 01 zero result, 11 invalid input
//   cnt_invalid   saturating count of accepted class-11 pairs
//   cnt_zero      saturating count of accepted class-01 pairs

module hp_mul_prep #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      hp_inA,
    input  logic [15:0]      hp_inB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [12:0]      booth_manA,
    output logic [12:0]      booth_manB,
    output logic [6:0]       exp_sum,
    output logic             sign_product,
    output logic [1:0]       op_class,
    output logic [CNT_W-1:0] cnt_invalid,
    output logic [CNT_W-1:0] cnt_zero
);

    localparam logic [1:0] CLASS_NORMAL  = 2'b00;
    localparam logic [1:0] CLASS_ZERO    = 2'b01;
    localparam logic [1:0] CLASS_INVALID = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [12:0] man_a;
        logic [12:0] man_b;
        logic [6:0]  exp_sum;
        logic        sign;
        logic [1:0]  op_class;
    } entry_t;

    logic [4:0] exp_a;
    logic [4:0] exp_b;
    logic [9:0] man_a;
    logic [9:0] man_b;

    entry_t     prep;
    entry_t     head_q;
    entry_t     tail_q;
    logic [1:0] count_q;
    logic [1:0] count_next;
    logic       in_ready_q;
    logic       push;
    logic       pop;

    logic [CNT_W-1:0] cnt_invalid_q;
    logic [CNT_W-1:0] cnt_zero_q;

    assign exp_a = hp_inA[14:10];
    assign exp_b = hp_inB[14:10];
    assign man_a = hp_inA[9:0];
    assign man_b = hp_inB[9:0];

    // Classify the incoming pair and build its prepared entry.
    // Infinity/NaN outranks denormal, which outranks zero, so a pair such as
    // Inf x 0 reports invalid rather than zero. Non-normal pairs carry zeroed
    // mantissa/exponent fields so the multiplier never sees stale operands.
    // The 7-bit exponent sum cannot wrap: normal exponents are 1..30, which
    // gives -13..45.
    always_comb begin
        prep          = '0;
        prep.sign     = hp_inA[15] ^ hp_inB[15];
        if ((exp_a == 5'd31) || (exp_b == 5'd31)) begin
            prep.op_class = CLASS_INVALID;
        end else if (((exp_a == 5'd0) && (man_a != 10'd0)) ||
                     ((exp_b == 5'd0) && (man_b != 10'd0))) begin
            prep.op_class = CLASS_INVALID;
        end else if ((exp_a == 5'd0) || (exp_b == 5'd0)) begin
            prep.op_class = CLASS_ZERO;
        end else begin
            prep.op_class = CLASS_NORMAL;
            prep.man_a    = {3'b001, man_a};
            prep.man_b    = {2'b01, man_b, 1'b0};
            prep.exp_sum  = {2'b00, exp_a} + {2'b00, exp_b} - 7'd15;
        end
    end

    // in_ready is a flop, so push never depends combinationally on out_ready.
    assign push = in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + 2'd1;
            2'b01:   count_next = count_q - 2'd1;
            default: count_next = count_q;
        endcase
    end

    // Two-slot FIFO: head_q always drives the outputs, tail_q holds the
    // second entry. With one entry present a simultaneous push and pop
    // writes the new entry straight into the head. A push can never coincide
    // with occupancy 2 because in_ready_q is low then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= 2'd0;
            in_ready_q    <= 1'b0;
            cnt_invalid_q <= '0;
            cnt_zero_q    <= '0;
        end else begin
            count_q    <= count_next;
            in_ready_q <= (count_next != 2'd2);

            if (pop) begin
                if (count_q == 2'd2) begin
                    head_q <= tail_q;
                end else if (push) begin
                    head_q <= prep;
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    head_q <= prep;
                end else begin
                    tail_q <= prep;
                end
            end

            // Statistics count accepted pairs only; stalls and pops leave them.
            if (push && (prep.op_class == CLASS_INVALID) && (cnt_invalid_q != CNT_MAX)) begin
                cnt_invalid_q <= cnt_invalid_q + CNT_ONE;
            end
            if (push && (prep.op_class == CLASS_ZERO) && (cnt_zero_q != CNT_MAX)) begin
                cnt_zero_q <= cnt_zero_q + CNT_ONE;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (count_q != 2'd0);
    assign booth_manA   = head_q.man_a;
    assign booth_manB   = head_q.man_b;
    assign exp_sum      = head_q.exp_sum;
    assign sign_product = head_q.sign;
    assign op_class     = head_q.op_class;
    assign cnt_invalid  = cnt_invalid_q;
    assign cnt_zero     = cnt_zero_q;

endmodule

// File: tb/tb_hp_mul_prep.sv
// tb_hp_mul_prep
// Directed-vector bench for hp_mul_prep. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point.

module tb_hp_mul_prep;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      hp_inA;
    logic [15:0]      hp_inB;
    logic             out_valid;
    logic             out_ready;
    logic [12:0]      booth_manA;
    logic [12:0]      booth_manB;
    logic [6:0]       exp_sum;
    logic             sign_product;
    logic [1:0]       op_class;
    logic [CNT_W-1:0] cnt_invalid;
    logic [CNT_W-1:0] cnt_zero;

    int errors = 0;
    int checks = 0;

    hp_mul_prep #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .hp_inA       (hp_inA),
        .hp_inB       (hp_inB),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .booth_manA   (booth_manA),
        .booth_manB   (booth_manB),
        .exp_sum      (exp_sum),
        .sign_product (sign_product),
        .op_class     (op_class),
        .cnt_invalid  (cnt_invalid),
        .cnt_zero     (cnt_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkEntry(input string tag, input logic [12:0] man_a,
                              input logic [12:0] man_b, input logic [6:0] exp_s,
                              input logic sign, input logic [1:0] cls);
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, ".booth_manA"}, {19'd0, booth_manA}, {19'd0, man_a});
        checkOutput({tag, ".booth_manB"}, {19'd0, booth_manB}, {19'd0, man_b});
        checkOutput({tag, ".exp_sum"}, {25'd0, exp_sum}, {25'd0, exp_s});
        checkOutput({tag, ".sign"}, {31'd0, sign_product}, {31'd0, sign});
        checkOutput({tag, ".op_class"}, {30'd0, op_class}, {30'd0, cls});
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] a,
                                 input logic [15:0] b, input logic oready);
        in_valid  = valid;
        hp_inA    = a;
        hp_inB    = b;
        out_ready = oready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Normal-class vectors, expected values computed by hand.
    logic [15:0] nA   [4] = '{16'h3C00, 16'h4000, 16'h0400, 16'h7BFF};
    logic [15:0] nB   [4] = '{16'h3C00, 16'hBE00, 16'h0400, 16'h7BFF};
    logic [12:0] nMA  [4] = '{13'h0400, 13'h0400, 13'h0400, 13'h07FF};
    logic [12:0] nMB  [4] = '{13'h0800, 13'h0C00, 13'h0800, 13'h0FFE};
    logic [6:0]  nExp [4] = '{7'd15,    7'd16,    7'h73,    7'd45};
    logic        nSgn [4] = '{1'b0,     1'b1,     1'b0,     1'b0};

    // Special-class vectors: Inf, denormal, zero.
    logic [15:0] sA   [3] = '{16'h7C00, 16'h0001, 16'h0000};
    logic [15:0] sB   [3] = '{16'h3C00, 16'h3C00, 16'h4000};
    logic [1:0]  sCls [3] = '{2'b11,    2'b11,    2'b01};

    initial begin
        int expCnt;

        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst.cnt_invalid", {24'd0, cnt_invalid}, 32'd0);
        checkOutput("rst.cnt_zero", {24'd0, cnt_zero}, 32'd0);
        checkOutput("rst.fields", {booth_manA, booth_manB, exp_sum[5:0]}, 32'd0);

        rst_n = 1'b1;
        tick();
        checkOutput("release.in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("release.out_valid", {31'd0, out_valid}, 32'd0);

        // Normal pairs, one at a time, latency 1 then popped.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, nA[i], nB[i], 1'b1);
            tick();
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
            checkEntry($sformatf("norm%0d", i), nMA[i], nMB[i], nExp[i], nSgn[i], 2'b00);
            tick();
            checkOutput($sformatf("norm%0d.drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-to-back special classes with out_ready held high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, sA[i], sB[i], 1'b1);
            tick();
            checkEntry($sformatf("class%0d", i), 13'd0, 13'd0, 7'd0, 1'b0, sCls[i]);
        end
        checkOutput("class.cnt_invalid", {24'd0, cnt_invalid}, 32'd2);
        checkOutput("class.cnt_zero", {24'd0, cnt_zero}, 32'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        checkOutput("class.drained", {31'd0, out_valid}, 32'd0);
        checkOutput("class.cnt_hold", {24'd0, cnt_invalid}, 32'd2);

        // Backpressure: three pairs against a stalled consumer.
        applyStimulus(1'b1, 16'h3C00, 16'h4000, 1'b0);
        tick();
        checkOutput("bp.p1.in_ready", {31'd0, in_ready}, 32'd1);
        checkEntry("bp.p1", 13'h0400, 13'h0800, 7'd16, 1'b0, 2'b00);
        applyStimulus(1'b1, 16'hC200, 16'h3E00, 1'b0);
        tick();
        checkOutput("bp.full.in_ready", {31'd0, in_ready}, 32'd0);
        checkEntry("bp.head_p1", 13'h0400, 13'h0800, 7'd16, 1'b0, 2'b00);
        applyStimulus(1'b1, 16'h4400, 16'h4400, 1'b0);
        tick();
        checkOutput("bp.held.in_ready", {31'd0, in_ready}, 32'd0);
        checkEntry("bp.stable_p1", 13'h0400, 13'h0800, 7'd16, 1'b0, 2'b00);
        applyStimulus(1'b1, 16'h4400, 16'h4400, 1'b1);
        tick();
        checkOutput("bp.pop1.in_ready", {31'd0, in_ready}, 32'd1);
        checkEntry("bp.head_p2", 13'h0600, 13'h0C00, 7'd16, 1'b1, 2'b00);
        tick();
        checkEntry("bp.head_p3", 13'h0400, 13'h0800, 7'd19, 1'b0, 2'b00);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        checkOutput("bp.drained", {31'd0, out_valid}, 32'd0);

        // Reset while the FIFO is full.
        applyStimulus(1'b1, 16'h3C00, 16'h3C00, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h4000, 16'h4000, 1'b0);
        tick();
        checkOutput("rst2.full", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b0;
        tick();
        checkOutput("rst2.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst2.in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst2.cnt_invalid", {24'd0, cnt_invalid}, 32'd0);
        checkOutput("rst2.cnt_zero", {24'd0, cnt_zero}, 32'd0);
        checkOutput("rst2.fields", {booth_manA, booth_manB, exp_sum[5:0]}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst2.release.in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst2.release.out_valid", {31'd0, out_valid}, 32'd0);

        // Saturation: 300 zero-class pairs accepted back to back.
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                expCnt = (i > 255) ? 255 : i;
                checkOutput($sformatf("sat%0d.cnt_zero", i), {24'd0, cnt_zero}, expCnt);
                checkOutput($sformatf("sat%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            end
        end
        checkOutput("sat.cnt_invalid", {24'd0, cnt_invalid}, 32'd0);
        checkEntry("sat.head", 13'd0, 13'd0, 7'd0, 1'b0, 2'b01);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        checkOutput("sat.final_cnt", {24'd0, cnt_zero}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hp_mul_prep.md
HP_MUL_PREP -- requirements
Module: hp_mul_prep

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each saturating statistics counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low, sampled on rising clk edge.
REQ-004 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 SHALL have port hp_inA  input  16  half-precision operand A: sign[15], exp[14:10], man[9:0].
REQ-007 SHALL have port hp_inB  input  16  half-precision operand B, same format.
REQ-008 SHALL have port out_valid  output  1  head entry valid toward multiplier stage.
REQ-009 SHALL have port out_ready  input  1  multiplier stage consumes head entry.
REQ-010 SHALL have port booth_manA  output  13  {3'b001, man_A} for normal class, else 0.
REQ-011 SHALL have port booth_manB  output  13  {2'b01, man_B, 1'b0} for normal class, else 0.
REQ-012 SHALL have port exp_sum  output  7  signed exp_A + exp_B - 15 for normal class, else 0.
REQ-013 SHALL have port sign_product  output  1  sign_A XOR sign_B, all classes.
REQ-014 SHALL have port op_class  output  2  00 normal, 01 zero result, 11 invalid input; 10 unused.
REQ-015 SHALL have ports cnt_invalid and cnt_zero  output  CNT_W  saturating counts of accepted invalid / zero-class pairs.

Function
REQ-016 SHALL hold a 2-entry FIFO of prepared entries {booth_manA, booth_manB, exp_sum, sign_product, op_class}; all fields computed from the inputs at the acceptance edge.
REQ-017 SHALL accept a pair on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 iff occupancy < 2 and rst_n was high at the last edge (registered, no combinational path from out_ready).
REQ-018 SHALL present entries in acceptance order; out_valid=1 iff occupancy > 0; head pops on an edge with out_valid=1 and out_ready=1.
REQ-019 SHALL have latency 1: pair accepted at edge N into an empty FIFO drives out_valid=1 with its fields after edge N.
REQ-020 SHALL handle simultaneous push and pop at occupancy 1: occupancy stays 1, new entry becomes head after the edge; at occupancy 2 no push occurs (in_ready=0), a pop sets occupancy 1 and in_ready=1 next cycle.
REQ-021 SHALL keep output fields stable while out_valid=1 and out_ready=0.
REQ-022 SHALL classify with priority: exp=31 on either operand (infinity or NaN) -> 11; else exp=0 with man!=0 on either (denormal) -> 11; else exp=0 with man=0 on either (zero) -> 01; else 00.
REQ-023 SHALL compute exp_sum in 7-bit two's complement without wrap (normal range -13..45).
REQ-024 SHALL increment cnt_invalid / cnt_zero by 1 on each accepted pair of class 11 / 01, saturating at 2^CNT_W-1; no change on stall or pop.
REQ-025 SHALL ignore hp_inA/hp_inB and in_valid when in_ready=0.

Reset
REQ-026 SHALL, on an edge with rst_n=0, set occupancy 0, out_valid=0, in_ready=0, all output fields 0, both counters 0, discarding in-flight entries regardless of handshake state.
REQ-027 SHALL drive in_ready=1 after the first edge with rst_n=1.

Verification
REQ-028 SHALL verify 0x3C00 x 0x3C00 -> next cycle out_valid=1, booth_manA=0x0400, booth_manB=0x0800, exp_sum=15, sign_product=0, op_class=00.
REQ-029 SHALL verify 0x4000 x 0xBE00 -> booth_manA=0x0400, booth_manB=0x0C00, exp_sum=16, sign_product=1, op_class=00.
REQ-030 SHALL verify 0x7C00 x 0x3C00, then 0x0001 x 0x3C00, then 0x0000 x 0x4000 -> classes 11, 11, 01, zeroed fields, cnt_invalid=2, cnt_zero=1.
REQ-031 SHALL verify out_ready=0 with 3 back-to-back valid pairs -> 2 accepted, in_ready=0, third held; out_ready=1 then drains in order, third accepted one cycle after first pop.
REQ-032 SHALL verify rst_n=0 for one edge with occupancy 2 -> out_valid=0, in_ready=0, counters 0; in_ready=1 one edge after release.
REQ-033 SHALL verify 300 accepted zero-class pairs with CNT_W=8 -> cnt_zero saturates at 255.
